// File: rtl/jfpjc_pkg.sv
// Shared constants and FSM encoding for the jfpjc JFIF framing path.
package jfpjc_pkg;

   localparam int         HEADER_LEN     = 328;
   localparam logic [7:0] JPEG_MARKER_FF = 8'hFF;
   localparam logic [7:0] JPEG_EOI       = 8'hD9;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_PAYLOAD,
      ST_EOI_FF,
      ST_EOI_D9
   } wrap_state_e;

endpackage

// File: rtl/jfpjc_byte_fifo.sv
// Byte FIFO with registered (1-cycle) read data and wrap-bit pointers; storage maps onto one EBR.
module jfpjc_byte_fifo #(
   parameter int DEPTH = 512,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          nreset,
   input  logic          clr_i,
   input  logic          push_i,
   input  logic [7:0]    wdata_i,
   input  logic          pop_i,
   output logic [7:0]    rdata_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [AW:0]   count_o
);

   logic [7:0]  mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, rd_ptr_q;
   logic [7:0]  rdata_q;
   logic        wr_ok, rd_ok;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign count_o = wr_ptr_q - rd_ptr_q;
   assign full_o  = (count_o == (AW+1)'(DEPTH));

   // A pop in the same cycle frees the head slot, so a full FIFO still takes the push.
   assign rd_ok = pop_i & ~empty_o;
   assign wr_ok = push_i & (~full_o | rd_ok);

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_ok && !clr_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
      if (rd_ok && !clr_i) rdata_q <= mem_q[rd_ptr_q[AW-1:0]];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/jfpjc_frame_wrapper.sv
// Wraps the compressor byte stream into a JFIF file: ROM header, buffered payload, then FF D9.
module jfpjc_frame_wrapper #(
   parameter int HEADER_LEN     = jfpjc_pkg::HEADER_LEN,
   parameter int HDR_ADDR_WIDTH = 9,
   parameter int FIFO_DEPTH     = 512
) (
   input  logic                      clock,
   input  logic                      nreset,
   input  logic                      frame_start,
   input  logic                      frame_end,
   input  logic [7:0]                data_in,
   input  logic                      data_good,
   output logic [HDR_ADDR_WIDTH-1:0] header_ebr_raddr,
   output logic                      header_ebr_ren,
   output logic                      header_ebr_rclk,
   input  logic [7:0]                header_ebr_dout,
   output logic [7:0]                data_out,
   output logic                      data_valid,
   input  logic                      data_ready,
   output logic                      frame_busy,
   output logic                      overflow,
   output logic                      frame_overrun
);
   import jfpjc_pkg::*;

   localparam int FAW = $clog2(FIFO_DEPTH);
   localparam logic [HDR_ADDR_WIDTH-1:0] HDR_LAST = HDR_ADDR_WIDTH'(HEADER_LEN - 1);

   wrap_state_e               state_q, state_d;
   logic [HDR_ADDR_WIDTH-1:0] hdr_idx_q, hdr_idx_d;
   logic                      hdr_done_q, hdr_done_d;
   logic                      rom_vld_q, rom_vld_d;
   logic                      fifo_vld_q, fifo_vld_d;
   logic [7:0]                dout_q, dout_d;
   logic                      dvalid_q, dvalid_d;
   logic                      overflow_q, overflow_d;
   logic                      overrun_q, overrun_d;
   logic                      eoi_pend_q, eoi_pend_d;

   logic                      accept, out_free, busy;
   logic                      hdr_ren, fifo_clr, fifo_push, fifo_pop;
   logic                      fifo_full, fifo_empty;
   logic [7:0]                fifo_rdata;
   logic [FAW:0]              fifo_count;

   assign busy     = (state_q != ST_IDLE);
   assign accept   = dvalid_q & data_ready;
   assign out_free = ~dvalid_q | accept;

   jfpjc_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock   (clock),
      .nreset  (nreset),
      .clr_i   (fifo_clr),
      .push_i  (fifo_push),
      .wdata_i (data_in),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      state_d    = state_q;
      hdr_idx_d  = hdr_idx_q;
      hdr_done_d = hdr_done_q;
      rom_vld_d  = rom_vld_q;
      fifo_vld_d = fifo_vld_q;
      dout_d     = dout_q;
      dvalid_d   = dvalid_q & ~accept;
      overflow_d = overflow_q;
      overrun_d  = overrun_q;
      eoi_pend_d = eoi_pend_q;
      hdr_ren    = 1'b0;
      fifo_clr   = 1'b0;
      fifo_pop   = 1'b0;
      fifo_push  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Address 0 is fetched in the start cycle so the first header byte lands two cycles later.
            if (frame_start) begin
               state_d    = ST_HDR;
               fifo_clr   = 1'b1;
               overflow_d = 1'b0;
               overrun_d  = 1'b0;
               eoi_pend_d = frame_end;
               hdr_done_d = 1'b0;
               hdr_ren    = 1'b1;
            end
         end
         ST_HDR: begin
            hdr_ren = ~hdr_done_q & out_free;
            if (rom_vld_q && out_free) begin
               dout_d    = header_ebr_dout;
               dvalid_d  = 1'b1;
               rom_vld_d = 1'b0;
            end
            if (hdr_done_q && !rom_vld_q && accept) state_d = ST_PAYLOAD;
         end
         ST_PAYLOAD: begin
            fifo_pop = ~fifo_empty & out_free;
            if (fifo_vld_q && out_free) begin
               dout_d     = fifo_rdata;
               dvalid_d   = 1'b1;
               fifo_vld_d = 1'b0;
            end else if (eoi_pend_q && fifo_count == '0 && !fifo_vld_q && out_free) begin
               dout_d   = JPEG_MARKER_FF;
               dvalid_d = 1'b1;
               state_d  = ST_EOI_FF;
            end
         end
         ST_EOI_FF: begin
            if (accept) begin
               dout_d   = JPEG_EOI;
               dvalid_d = 1'b1;
               state_d  = ST_EOI_D9;
            end
         end
         ST_EOI_D9: begin
            if (accept) begin
               state_d    = ST_IDLE;
               hdr_idx_d  = '0;
               hdr_done_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // ROM and FIFO outputs hold while not re-read, so a stalled fetch simply waits in place.
      if (hdr_ren) begin
         rom_vld_d = 1'b1;
         if (hdr_idx_q == HDR_LAST) hdr_done_d = 1'b1;
         else                       hdr_idx_d  = hdr_idx_q + 1'b1;
      end
      if (fifo_pop) fifo_vld_d = 1'b1;

      if (busy) begin
         if (frame_start) overrun_d  = 1'b1;
         if (frame_end)   eoi_pend_d = 1'b1;
         if (data_good) begin
            if (fifo_full && !fifo_pop) overflow_d = 1'b1;
            else                        fifo_push  = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         state_q    <= ST_IDLE;
         hdr_idx_q  <= '0;
         hdr_done_q <= 1'b0;
         rom_vld_q  <= 1'b0;
         fifo_vld_q <= 1'b0;
         dout_q     <= 8'h00;
         dvalid_q   <= 1'b0;
         overflow_q <= 1'b0;
         overrun_q  <= 1'b0;
         eoi_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         hdr_idx_q  <= hdr_idx_d;
         hdr_done_q <= hdr_done_d;
         rom_vld_q  <= rom_vld_d;
         fifo_vld_q <= fifo_vld_d;
         dout_q     <= dout_d;
         dvalid_q   <= dvalid_d;
         overflow_q <= overflow_d;
         overrun_q  <= overrun_d;
         eoi_pend_q <= eoi_pend_d;
      end
   end

   assign header_ebr_raddr = hdr_idx_q;
   assign header_ebr_ren   = hdr_ren;
   assign header_ebr_rclk  = clock;
   assign data_out         = dout_q;
   assign data_valid       = dvalid_q;
   assign frame_busy       = busy;
   assign overflow         = overflow_q;
   assign frame_overrun    = overrun_q;

endmodule

// File: tb/tb_jfpjc_frame_wrapper.sv
// Directed bench: two wrappers (FIFO 512 and FIFO 16) share stimulus; each feature has its own task.
module tb_jfpjc_frame_wrapper;

   typedef logic [7:0] bq_t [$];

   logic       clock = 1'b0;
   logic       nreset, frame_start, frame_end, data_good, data_ready;
   logic [7:0] data_in;

   logic [8:0] raddr_a, raddr_b;
   logic       ren_a, ren_b, rclk_a, rclk_b;
   logic [7:0] rom_a, rom_b, do_a, do_b;
   logic       dv_a, dv_b, busy_a, busy_b, ovf_a, ovf_b, ovr_a, ovr_b;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   bq_t  q_a, q_b;
   int   st_a[$];
   int   start_cyc, end_a, end_b, hold_a, hold_b, k_last;
   logic busy1_a, ovf1_b;
   bit   tmo;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [7:0] hdr_byte(input int i);
      return 8'((i * 37 + 11) & 255);
   endfunction

   function automatic bq_t exp_stream(input int npay);
      bq_t q;
      for (int i = 0; i < 328; i++) q.push_back(hdr_byte(i));
      for (int i = 0; i < npay; i++) q.push_back(8'(i));
      q.push_back(8'hFF);
      q.push_back(8'hD9);
      return q;
   endfunction

   // Index of first difference between two byte streams, -1 when identical.
   function automatic int first_diff(input bq_t got, input bq_t exp);
      int n;
      n = (got.size() < exp.size()) ? got.size() : exp.size();
      for (int i = 0; i < n; i++) if (got[i] !== exp[i]) return i;
      return (got.size() == exp.size()) ? -1 : n;
   endfunction

   always @(posedge rclk_a) if (ren_a) rom_a <= hdr_byte(int'(raddr_a));
   always @(posedge rclk_b) if (ren_b) rom_b <= hdr_byte(int'(raddr_b));

   always @(negedge clock) begin
      if (nreset && dv_a && data_ready) begin q_a.push_back(do_a); st_a.push_back(cyc); end
      if (nreset && dv_b && data_ready) q_b.push_back(do_b);
   end

   jfpjc_frame_wrapper dut_a (
      .clock(clock), .nreset(nreset), .frame_start(frame_start), .frame_end(frame_end),
      .data_in(data_in), .data_good(data_good), .header_ebr_raddr(raddr_a),
      .header_ebr_ren(ren_a), .header_ebr_rclk(rclk_a), .header_ebr_dout(rom_a),
      .data_out(do_a), .data_valid(dv_a), .data_ready(data_ready), .frame_busy(busy_a),
      .overflow(ovf_a), .frame_overrun(ovr_a));

   jfpjc_frame_wrapper #(.FIFO_DEPTH(16)) dut_b (
      .clock(clock), .nreset(nreset), .frame_start(frame_start), .frame_end(frame_end),
      .data_in(data_in), .data_good(data_good), .header_ebr_raddr(raddr_b),
      .header_ebr_ren(ren_b), .header_ebr_rclk(rclk_b), .header_ebr_dout(rom_b),
      .data_out(do_b), .data_valid(dv_b), .data_ready(data_ready), .frame_busy(busy_b),
      .overflow(ovf_b), .frame_overrun(ovr_b));

   // Runs one frame on both DUTs and returns once both are idle again (or the cycle budget expires).
   task automatic drive_frame(input int nbytes, input bit end_now, input bit rnd,
                              input int stall, input int restart_at);
      logic       pv_a, pv_b, pr;
      logic [7:0] pd_a, pd_b;
      int         k;
      q_a.delete(); q_b.delete(); st_a.delete();
      hold_a = 0; hold_b = 0; end_a = -1; end_b = -1; tmo = 0;
      pv_a = 1'b0; pv_b = 1'b0; pr = 1'b1; pd_a = 8'h00; pd_b = 8'h00;
      k = 0;
      while (1) begin
         @(posedge clock); #1;
         if (pv_a && !pr && (dv_a !== 1'b1 || do_a !== pd_a)) hold_a++;
         if (pv_b && !pr && (dv_b !== 1'b1 || do_b !== pd_b)) hold_b++;
         if (k == 1) begin busy1_a = busy_a; ovf1_b = ovf_b; end
         if (k >= 2 && end_a < 0 && !busy_a) end_a = cyc;
         if (k >= 2 && end_b < 0 && !busy_b) end_b = cyc;
         if (end_a >= 0 && end_b >= 0) break;
         if (k > 4000) begin tmo = 1; break; end
         if (k == 0) start_cyc = cyc;
         frame_start = (k == 0) || (restart_at > 0 && k == restart_at);
         frame_end   = end_now ? (k == 0) : (k == nbytes + 1);
         data_good   = (k >= 1 && k <= nbytes);
         data_in     = 8'(k - 1);
         data_ready  = (k < stall) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
         pv_a = dv_a; pd_a = do_a; pv_b = dv_b; pd_b = do_b; pr = data_ready;
         k++;
      end
      k_last = k;
      frame_start = 1'b0; frame_end = 1'b0; data_good = 1'b0; data_ready = 1'b1;
   endtask

   task automatic test_reset();
      nreset = 1'b0; frame_start = 1'b0; frame_end = 1'b0; data_good = 1'b0;
      data_in = 8'h00; data_ready = 1'b1;
      repeat (3) @(posedge clock); #1;
      checks++; if (dv_a !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", dv_a); end
      checks++; if (do_a !== 8'h00) begin errors++; $display("FAIL rst_dout: got %h want 00", do_a); end
      checks++; if (ren_a !== 1'b0) begin errors++; $display("FAIL rst_ren: got %b want 0", ren_a); end
      checks++; if (raddr_a !== 9'd0) begin errors++; $display("FAIL rst_raddr: got %0d want 0", raddr_a); end
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_a); end
      checks++; if (ovf_a !== 1'b0 || ovr_a !== 1'b0) begin errors++; $display("FAIL rst_sticky: got ovf=%b ovr=%b want 0 0", ovf_a, ovr_a); end
      nreset = 1'b1;
      repeat (2) @(posedge clock); #1;
      checks++; if (dv_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL idle_after_rst: got valid=%b busy=%b want 0 0", dv_a, busy_a); end
   endtask

   task automatic test_header_only();
      int d;
      drive_frame(0, 1'b0, 1'b0, 0, 0);
      checks++; if (tmo) begin errors++; $display("FAIL t1_timeout: frame did not finish within budget"); end
      checks++; if (busy1_a !== 1'b1) begin errors++; $display("FAIL t1_busy_rise: got %b want 1", busy1_a); end
      d = first_diff(q_a, exp_stream(0));
      checks++; if (d >= 0) begin errors++; $display("FAIL t1_stream: diff at %0d, got len %0d want 330", d, q_a.size()); end
      checks++; if (st_a[0] !== start_cyc + 2) begin errors++; $display("FAIL t1_first_lat: got cycle %0d want %0d", st_a[0], start_cyc + 2); end
      checks++; if (st_a[327] !== start_cyc + 329) begin errors++; $display("FAIL t1_hdr_rate: last hdr cycle %0d want %0d", st_a[327], start_cyc + 329); end
      checks++; if (end_a !== st_a[329] + 1) begin errors++; $display("FAIL t1_busy_fall: got cycle %0d want %0d", end_a, st_a[329] + 1); end
   endtask

   task automatic test_payload();
      int d;
      drive_frame(100, 1'b0, 1'b0, 0, 0);
      d = first_diff(q_a, exp_stream(100));
      checks++; if (tmo || d >= 0) begin errors++; $display("FAIL t2_stream: diff at %0d, got len %0d want 430 tmo=%0d", d, q_a.size(), tmo); end
      checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL t2_overflow: got %b want 0", ovf_a); end
   endtask

   task automatic test_random_ready();
      int d;
      drive_frame(100, 1'b0, 1'b1, 0, 0);
      d = first_diff(q_a, exp_stream(100));
      checks++; if (tmo || d >= 0) begin errors++; $display("FAIL t3_stream: diff at %0d, got len %0d want 430 tmo=%0d", d, q_a.size(), tmo); end
      checks++; if (hold_a !== 0 || hold_b !== 0) begin errors++; $display("FAIL t3_hold: got %0d/%0d unstable cycles want 0", hold_a, hold_b); end
   endtask

   task automatic test_overflow();
      int d;
      drive_frame(20, 1'b0, 1'b0, 400, 0);
      d = first_diff(q_b, exp_stream(16));
      checks++; if (tmo || d >= 0) begin errors++; $display("FAIL t4_stream16: diff at %0d, got len %0d want 346", d, q_b.size()); end
      checks++; if (ovf_b !== 1'b1) begin errors++; $display("FAIL t4_overflow16: got %b want 1", ovf_b); end
      d = first_diff(q_a, exp_stream(20));
      checks++; if (d >= 0 || ovf_a !== 1'b0) begin errors++; $display("FAIL t4_stream512: diff at %0d ovf=%b want -1 0", d, ovf_a); end
      checks++; if (hold_b !== 0) begin errors++; $display("FAIL t4_hold: got %0d unstable cycles want 0", hold_b); end
      drive_frame(0, 1'b0, 1'b0, 0, 0);
      checks++; if (ovf1_b !== 1'b0 || ovf_b !== 1'b0) begin errors++; $display("FAIL t4_ovf_clear: got %b/%b want 0", ovf1_b, ovf_b); end
   endtask

   task automatic test_overrun_and_reset();
      int d;
      drive_frame(100, 1'b0, 1'b0, 0, 340);
      d = first_diff(q_a, exp_stream(100));
      checks++; if (tmo || d >= 0) begin errors++; $display("FAIL t5_stream: diff at %0d, got len %0d want 430", d, q_a.size()); end
      checks++; if (ovr_a !== 1'b1 || ovr_b !== 1'b1) begin errors++; $display("FAIL t5_overrun: got %b/%b want 1", ovr_a, ovr_b); end
      repeat (3) @(posedge clock); #1;
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL t5_no_restart: got busy %b want 0", busy_a); end
      frame_start = 1'b1;
      @(posedge clock); #1;
      frame_start = 1'b0;
      repeat (20) @(posedge clock);
      #1;
      checks++; if (dv_a !== 1'b1 || busy_a !== 1'b1) begin errors++; $display("FAIL t5_midhdr: got valid=%b busy=%b want 1 1", dv_a, busy_a); end
      #2; nreset = 1'b0; #1;
      checks++; if (dv_a !== 1'b0 || busy_a !== 1'b0 || ovr_a !== 1'b0) begin errors++; $display("FAIL t5_async_rst: got valid=%b busy=%b ovr=%b want 0 0 0", dv_a, busy_a, ovr_a); end
      checks++; if (raddr_a !== 9'd0) begin errors++; $display("FAIL t5_rst_raddr: got %0d want 0", raddr_a); end
      @(posedge clock); #1;
      nreset = 1'b1;
      drive_frame(0, 1'b0, 1'b0, 0, 0);
      d = first_diff(q_a, exp_stream(0));
      checks++; if (tmo || d >= 0 || st_a[0] !== start_cyc + 2) begin errors++; $display("FAIL t5_restart: diff at %0d first cycle %0d want -1 %0d", d, st_a[0], start_cyc + 2); end
   endtask

   task automatic test_start_end_same();
      int d;
      drive_frame(0, 1'b1, 1'b0, 0, 0);
      d = first_diff(q_a, exp_stream(0));
      checks++; if (tmo || d >= 0) begin errors++; $display("FAIL t6_stream: diff at %0d, got len %0d want 330", d, q_a.size()); end
      checks++; if (q_a.size() >= 2 && (q_a[328] !== 8'hFF || q_a[329] !== 8'hD9)) begin errors++; $display("FAIL t6_eoi: got %h %h want ff d9", q_a[328], q_a[329]); end
   endtask

   initial begin
      test_reset();
      test_header_only();
      test_payload();
      test_random_ready();
      test_overflow();
      test_overrun_and_reset();
      test_start_end_same();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
